// File: rtl/scroll_pkg.sv
// Shared glyph codes, blank code and controller state encoding for the message scroller.
package scroll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCROLL
    } state_t;

    localparam logic [3:0] GLYPH_O     = 4'd0;
    localparam logic [3:0] GLYPH_T     = 4'd1;
    localparam logic [3:0] GLYPH_BLANK = 4'd2;
    localparam logic [3:0] GLYPH_E     = 4'd3;
    localparam logic [3:0] GLYPH_H     = 4'd4;
    localparam logic [3:0] GLYPH_L     = 4'd7;
    localparam logic [3:0] GLYPH_R     = 4'd8;

    localparam logic [3:0] BLANK = GLYPH_BLANK;

endpackage

// File: rtl/tick_divider.sv
// Scroll-rate divider: counts 0..TICK_DIV-1 while enabled and emits a one-cycle step at terminal count.
module tick_divider #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic step
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // Holding the count while disabled keeps a due step pending rather than dropping it.
    assign step = enable && (count == TERM);

    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (enable)
            count <= step ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/message_scroller.sv
// Loads a glyph message and scrolls a 4-digit window across it, with a blank gap before wrapping.
// Optional SCROLL_PAUSE_EN adds a pause input that freezes scrolling.
module message_scroller
    import scroll_pkg::*;
#(
    parameter int MSG_DEPTH = 16,
    parameter int TICK_DIV  = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_start,
`ifdef SCROLL_PAUSE_EN
    input  logic       pause,
`endif
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [3:0] wr_char,
    input  logic       wr_last,
    output logic [3:0] fourth,
    output logic [3:0] third,
    output logic [3:0] second,
    output logic [3:0] first,
    output logic       busy,
    output logic       wrap
);

    localparam int LW = $clog2(MSG_DEPTH + 1);
    localparam int AW = $clog2(MSG_DEPTH);
    localparam int IW = LW + 1;

    state_t          state, state_d;
    logic [LW-1:0]   len, ptr;
    logic [3:0]      mem [MSG_DEPTH];
    logic            accept, full_write, step, tick_en, tick_clr;
    logic [3:0][3:0] win;

    assign wr_ready   = (state == ST_LOAD);
    assign busy       = (state == ST_LOAD);
    assign accept     = wr_valid && wr_ready && !load_start;
    assign full_write = (len == LW'(MSG_DEPTH - 1));

`ifdef SCROLL_PAUSE_EN
    assign tick_en = (state == ST_SCROLL) && !pause;
`else
    assign tick_en = (state == ST_SCROLL);
`endif
    assign tick_clr = load_start || (state != ST_SCROLL);

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock  (clock),
        .reset  (reset),
        .enable (tick_en),
        .clear  (tick_clr),
        .step   (step)
    );

    always_comb begin
        state_d = state;
        if (load_start)
            state_d = ST_LOAD;
        else if (accept && (wr_last || full_write))
            state_d = ST_SCROLL;
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clock) begin
        if (accept)
            mem[len[AW-1:0]] <= wr_char;
    end

    // ptr stays 0 throughout LOAD, so SCROLL always starts at the message head.
    always_ff @(posedge clock) begin
        if (reset) begin
            len  <= '0;
            ptr  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load_start) begin
                len <= '0;
                ptr <= '0;
            end else begin
                if (accept)
                    len <= len + 1'b1;
                if (step) begin
                    if (ptr == len) begin
                        ptr  <= '0;
                        wrap <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
            end
        end
    end

    // Window index reduced mod P=len+1; three subtractions cover the P=2 worst case.
    always_comb begin
        for (int d = 0; d < 4; d++) begin
            logic [IW-1:0] idx;
            idx = IW'(ptr) + IW'(d);
            for (int k = 0; k < 3; k++)
                if (idx > IW'(len))
                    idx = idx - (IW'(len) + 1'b1);
            win[3-d] = (idx == IW'(len)) ? BLANK : mem[idx[AW-1:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (reset || state != ST_SCROLL)
            {fourth, third, second, first} <= {4{BLANK}};
        else
            {fourth, third, second, first} <= win;
    end

endmodule

// File: tb/tb_message_scroller.sv
// Self-checking bench for message_scroller at MSG_DEPTH=16, TICK_DIV=4 (default build, no pause).
module tb_message_scroller;

    localparam int MSG_DEPTH = 16;
    localparam int TICK_DIV  = 4;

    logic       clock = 1'b0;
    logic       reset, load_start, wr_valid, wr_ready, wr_last, busy, wrap;
    logic [3:0] wr_char, fourth, third, second, first;

    always #5 clock = ~clock;

    message_scroller #(.MSG_DEPTH(MSG_DEPTH), .TICK_DIV(TICK_DIV)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_start (load_start),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_char    (wr_char),
        .wr_last    (wr_last),
        .fourth     (fourth),
        .third      (third),
        .second     (second),
        .first      (first),
        .busy       (busy),
        .wrap       (wrap)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];

    typedef struct {
        string       name;
        logic [63:0] msg;   // glyph j in bits [4j+3:4j]
        int          len;
        int          nsteps;
        logic [15:0] e0, e1, elast;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [15:0] digits();
        return {fourth, third, second, first};
    endfunction

    // Window of the message-plus-blank sequence starting at position p.
    function automatic logic [15:0] model(input logic [63:0] m, input int L, input int p);
        logic [15:0] r;
        r = '0;
        for (int d = 0; d < 4; d++) begin
            int j;
            j = (p + d) % (L + 1);
            r = {r[11:0], (j < L) ? m[4*j +: 4] : 4'd2};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic put(input logic [3:0] ch, input logic last);
        wr_valid = 1'b1;
        wr_char  = ch;
        wr_last  = last;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic load_msg(input string nm, input logic [63:0] m, input int L);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk({nm, " load busy/ready"}, {30'd0, busy, wr_ready}, 32'd3);
        for (int j = 0; j < L; j++)
            put(m[4*j +: 4], j == L - 1);
    endtask

    // Called right after the entering write edge; samples each scroll window and its hold.
    task automatic run_scroll(input string nm, input logic [63:0] m, input int L, input int n,
                              input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] elast);
        logic [15:0] exp, prev;
        int wraps;
        wraps = 0;
        prev  = 16'h2222;
        for (int k = 0; k <= n; k++)
            sb.push_back(model(m, L, k % (L + 1)));
        for (int c = 1; c <= 1 + 4 * n; c++) begin
            tick();
            wr_valid = 1'b0;
            if (wrap) wraps++;
            if (c % 4 == 0)
                chk({nm, " hold"}, {16'd0, digits()}, {16'd0, prev});
            if ((c - 1) % 4 == 0) begin
                int k;
                k = (c - 1) / 4;
                if (sb.size() == 0) begin
                    chk({nm, " scoreboard empty"}, 32'd0, 32'd1);
                end else begin
                    exp  = sb.pop_front();
                    prev = exp;
                    chk({nm, " window"}, {16'd0, digits()}, {16'd0, exp});
                end
                if (k == 0) chk({nm, " first window"}, {16'd0, digits()}, {16'd0, e0});
                if (k == 1) chk({nm, " second window"}, {16'd0, digits()}, {16'd0, e1});
                if (k == n) chk({nm, " last window"}, {16'd0, digits()}, {16'd0, elast});
            end
        end
        chk({nm, " wrap count"}, wraps, n / (L + 1));
    endtask

    initial begin
        reset = 1'b1; load_start = 1'b0; wr_valid = 1'b0; wr_char = '0; wr_last = 1'b0;

        vecs[0] = '{"HELLO", 64'h07734, 5, 6, 16'h4377, 16'h3770, 16'h4377};
        vecs[1] = '{"T",     64'h1,     1, 5, 16'h1212, 16'h2121, 16'h2121};
        vecs[2] = '{"OTE",   64'h310,   3, 5, 16'h0132, 16'h1320, 16'h1320};
        vecs[3] = '{"PASS",  64'h6F59,  4, 3, 16'h95F6, 16'h5F62, 16'h6295};

        tick(); tick();
        chk("reset outputs", {13'd0, digits(), wr_ready, busy, wrap}, {13'd0, 16'h2222, 3'b000});
        reset = 1'b0;
        tick();
        chk("idle outputs", {13'd0, digits(), wr_ready, busy, wrap}, {13'd0, 16'h2222, 3'b000});

        for (int i = 0; i < 4; i++) begin
            load_msg(vecs[i].name, vecs[i].msg, vecs[i].len);
            chk({vecs[i].name, " entered scroll"}, {31'd0, busy}, 32'd0);
            run_scroll(vecs[i].name, vecs[i].msg, vecs[i].len, vecs[i].nsteps,
                       vecs[i].e0, vecs[i].e1, vecs[i].elast);
        end

        // Full message without wr_last: 17th write must be refused.
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int j = 0; j < 16; j++)
            put(4'(j), 1'b0);
        chk("full entry busy", {31'd0, busy}, 32'd0);
        wr_valid = 1'b1; wr_char = 4'd9;
        chk("17th wr_ready", {31'd0, wr_ready}, 32'd0);
        run_scroll("FULL", 64'hFEDCBA9876543210, 16, 13, 16'h0123, 16'h1234, 16'hDEF2);

        // load_start on the same cycle as a wrapping step.
        load_msg("T2", 64'h1, 1);
        for (int c = 1; c <= 7; c++) tick();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("step+load busy", {31'd0, busy}, 32'd1);
        chk("step+load wrap", {31'd0, wrap}, 32'd0);
        tick();
        chk("step+load blank", {16'd0, digits()}, {16'd0, 16'h2222});
        chk("step+load wrap later", {31'd0, wrap}, 32'd0);
        for (int j = 0; j < 5; j++)
            put(vecs[0].msg[4*j +: 4], j == 4);
        run_scroll("RELOAD", vecs[0].msg, 5, 2, 16'h4377, 16'h3770, 16'h7702);

        // Reset in the middle of a load.
        load_start = 1'b1; tick(); load_start = 1'b0;
        put(4'd8, 1'b0); put(4'd8, 1'b0); put(4'd8, 1'b0);
        reset = 1'b1;
        tick();
        chk("midload reset", {13'd0, digits(), wr_ready, busy, wrap}, {13'd0, 16'h2222, 3'b000});
        reset = 1'b0;
        tick();
        chk("post reset idle", {13'd0, digits(), wr_ready, busy, wrap}, {13'd0, 16'h2222, 3'b000});
        load_msg("TH", 64'h41, 2);
        run_scroll("TH", 64'h41, 2, 2, 16'h1421, 16'h4214, 16'h2142);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/message_scroller.md
MESSAGE_SCROLLER -- requirements
Module: message_scroller

Interface
REQ-001 SHALL have parameter MSG_DEPTH, default 16: maximum message length in glyphs (2..64).
REQ-002 SHALL have parameter TICK_DIV, default 50000000: clock cycles per scroll step (1 s at 50 MHz).
REQ-003 SHALL have port clock, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port load_start, input, 1: one-cycle pulse that discards the current message and begins loading a new one.
REQ-006 SHALL have port wr_valid, input, 1: glyph write request.
REQ-007 SHALL have port wr_ready, output, 1: block accepts a glyph this cycle.
REQ-008 SHALL have port wr_char, input, 4: glyph code.
REQ-009 SHALL have port wr_last, input, 1: marks the final glyph of the message.
REQ-010 SHALL have ports fourth, third, second, first, output, 4 each: glyph codes for the leftmost through rightmost digit, fed to the display multiplexer.
REQ-011 SHALL have port busy, output, 1: high in LOAD.
REQ-012 SHALL have port wrap, output, 1: one-cycle pulse when the window wraps to the message start.

Function
REQ-013 SHALL implement states IDLE, LOAD and SCROLL.
REQ-014 SHALL use glyph codes O=0, T=1, blank=2, E=3, H=4, L=7, R=8, and pass all other codes through unchanged.
REQ-015 SHALL transfer a write on a cycle with wr_valid && wr_ready; wr_ready is 1 only in LOAD.
REQ-016 SHALL store accepted glyphs at consecutive addresses from 0, with length L equal to the write count.
REQ-017 SHALL move LOAD->SCROLL on the accepted write that has wr_last=1, or on the write that makes L=MSG_DEPTH (wr_last ignored).
REQ-018 SHALL move any state->LOAD on load_start, clearing L, ptr and the tick counter; load_start has priority over a same-cycle write or step.
REQ-019 SHALL use a virtual sequence S of period P=L+1: S[i]=msg[i] for i<L, S[L]=blank.
REQ-020 SHALL, in SCROLL, drive fourth=S[ptr], third=S[(ptr+1) mod P], second=S[(ptr+2) mod P], first=S[(ptr+3) mod P]; modulo applies repeatedly when P<4.
REQ-021 SHALL register the digit outputs, so they reflect a new ptr or state one cycle after the change.
REQ-022 SHALL drive all digit outputs to blank (2) in IDLE and LOAD.
REQ-023 SHALL run the tick counter 0..TICK_DIV-1 only in SCROLL; the terminal count generates a one-cycle step.
REQ-024 SHALL set ptr to (ptr+1) mod P on each step, and pulse wrap in the same cycle as the P-1->0 transition.
REQ-025 SHALL enter SCROLL with ptr=0 and tick counter=0.

Reset
REQ-026 SHALL, on reset, set state=IDLE, L=0, ptr=0, tick=0, wr_ready=0, busy=0, wrap=0, and all digit outputs to 2 (blank); message RAM contents are undefined.
REQ-027 SHALL make reset override load_start and writes; reset in the middle of a load discards the partial message.

Configuration
REQ-028 SHALL add, with SCROLL_PAUSE_EN defined, an input pause (1 bit) that holds the tick counter and ptr while high in SCROLL; the display stays static and a step due during pause is not lost but deferred.
REQ-029 SHALL, without SCROLL_PAUSE_EN, have no pause port and scroll free-running.

Structure
REQ-030 SHALL place glyph code constants, the state enumeration and the blank code in a shared package scroll_pkg.
REQ-031 SHALL implement the tick counter as sub-module tick_divider (parameter TICK_DIV, inputs clock, reset, enable, clear; output step).

Verification
REQ-032 SHALL cover TICK_DIV=4 with load H,E,L,L,O (wr_last on O): after entry the outputs read H,E,L,L (4,3,7,7), then E,L,L,O 4 cycles later, then L,L,O,blank.
REQ-033 SHALL cover the same message with 6 steps: ptr returns to 0 and wrap pulses exactly once, with the outputs back to 4,3,7,7.
REQ-034 SHALL cover a single glyph T (L=1, P=2): the outputs alternate 1,2,1,2 and 2,1,2,1 on each step.
REQ-035 SHALL cover 16 writes with wr_last=0 at MSG_DEPTH=16: SCROLL is entered after the 16th write, wr_ready=0 on the 17th cycle, and the 17th glyph is not stored.
REQ-036 SHALL cover load_start asserted in SCROLL concurrently with a step: the state becomes LOAD, the outputs go all blank the next cycle, ptr=0, and wrap does not pulse.
REQ-037 SHALL cover reset asserted after 3 writes in LOAD: state=IDLE, wr_ready=0 and all digits=2; a subsequent load_start plus 2 writes shows only the new glyphs.
